layer_mac_scheduler: RTL and testbench

Time-multiplexed neuron-layer engine and sequencer. It computes all N_OUT nodes of a fully connected layer serially through one shared multiply-accumulate path. It fetches activations and weights from synchronous-read memories, adds the per-node bias, and applies ReLU with Q13 rescaling. It sits between a layer's activation buffer/weight ROM and the next layer's input buffer, replacing a bank of parallel per-node MAC trees where area matters.

---
 rtl/layer_mac_scheduler.sv | 155 +++++++++++++++
 tb/tb_layer_mac_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/layer_mac_scheduler.sv
// layer_mac_scheduler
//   Serial fully connected layer engine. One shared multiply-accumulate path
//   walks every node in turn. For each node it reads N_IN activation/weight
//   pairs and then the node's bias from synchronous-read memories. The result
//   goes through ReLU and Q(FRAC) rescaling before it is presented on a
//   valid/ready output port.
//
//   Optional feature: define MAC_SAT_EN to make every accumulator add
//   saturate on signed overflow. The default build wraps modulo 2^32.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             begin a layer (accepted only in idle)
//   busy, done        layer in progress / one-cycle completion pulse
//   act_addr/act_data activation buffer address, data one cycle later
//   w_addr/w_data     weight ROM address (node-major, bias last), data one cycle later
//   out_valid/ready   result handshake
//   out_idx/out_data  node index and zero-extended 16-bit ReLU result
module layer_mac_scheduler #(
  parameter int unsigned N_IN  = 30,
  parameter int unsigned N_OUT = 8,
  parameter int unsigned FRAC  = 13,
  localparam int unsigned AAW  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int unsigned WAW  = $clog2(N_OUT * (N_IN + 1)),
  localparam int unsigned IW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [AAW-1:0]  act_addr,
  input  logic [31:0]     act_data,
  output logic [WAW-1:0]  w_addr,
  input  logic [31:0]     w_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   out_idx,
  output logic [31:0]     out_data
);

  localparam int unsigned KW = $clog2(N_IN + 1);
  localparam logic [KW-1:0]  KLast   = KW'(N_IN);
  localparam logic [IW-1:0]  NLast   = IW'(N_OUT - 1);
  localparam logic [WAW-1:0] NodeStr = WAW'(N_IN + 1);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StOut, StDone} state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [IW-1:0]  n_q, n_d;
  logic [WAW-1:0] base_q, base_d;
  logic [31:0]    acc_q, acc_d;
  // Delayed issue flags: memory data for an address arrives one cycle later.
  logic           pv_q, pv_d;
  logic           bias_q, bias_d;
  logic [31:0]    prod;

  function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
`ifdef MAC_SAT_EN
    if ((a[31] == b[31]) && (s[31] != a[31])) begin
      s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`endif
    return s;
  endfunction

  // Low 32 bits of a signed product equal those of the unsigned product.
  assign prod = act_data * w_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      pv_q    <= 1'b0;
      bias_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      pv_q    <= pv_d;
      bias_q  <= bias_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    base_d  = base_q;
    acc_d   = acc_q;
    pv_d    = 1'b0;
    bias_d  = 1'b0;

    if (pv_q) begin
      acc_d = acc_add(acc_q, prod);
    end else if (bias_q) begin
      acc_d = acc_add(acc_q, w_data);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          k_d     = '0;
          n_d     = '0;
          base_d  = '0;
          acc_d   = '0;
        end
      end
      StRun: begin
        pv_d   = (k_q != KLast);
        bias_d = (k_q == KLast);
        if (k_q == KLast) begin
          state_d = StDrain;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDrain: state_d = StOut;
      StOut: begin
        if (out_ready) begin
          if (n_q == NLast) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            n_d     = n_q + 1'b1;
            base_d  = base_q + NodeStr;
            k_d     = '0;
            acc_d   = '0;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy      = (state_q == StRun) || (state_q == StDrain) || (state_q == StOut);
  assign done      = (state_q == StDone);
  assign out_valid = (state_q == StOut);
  assign out_idx   = out_valid ? n_q : '0;
  assign out_data  = (out_valid && !acc_q[31]) ? {16'b0, acc_q[FRAC+15:FRAC]} : 32'b0;
  // Bias slot has no activation; park the activation address at zero.
  assign act_addr  = (k_q != KLast) ? AAW'(k_q) : '0;
  assign w_addr    = base_q + WAW'(k_q);

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Directed bench for layer_mac_scheduler with N_IN=3, N_OUT=2, FRAC=13.
// Activation and weight memories are modelled as synchronous-read arrays.
module tb_layer_mac_scheduler;

  localparam int unsigned NI = 3;
  localparam int unsigned NO = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  act_addr;
  logic [31:0] act_data;
  logic [2:0]  w_addr;
  logic [31:0] w_data;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_idx;
  logic [31:0] out_data;

  logic [31:0] act_mem [0:3];
  logic [31:0] w_mem   [0:7];

  int n_cmp = 0;
  int n_err = 0;

  layer_mac_scheduler #(.N_IN(NI), .N_OUT(NO), .FRAC(13)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .act_addr  (act_addr),
    .act_data  (act_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    act_data <= act_mem[act_addr];
    w_data   <= w_mem[w_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] b0,
                      input logic [31:0] w1, input logic [31:0] b1);
    for (int i = 0; i < 4; i++) act_mem[i] = a;
    for (int i = 0; i < 3; i++) begin
      w_mem[i]     = w0;
      w_mem[4 + i] = w1;
    end
    w_mem[3] = b0;
    w_mem[7] = b1;
  endtask

  // Runs one layer; cycle numbers are relative to the start-sampling edge E0.
  task automatic run_layer(input bit stall, input bit pulse, input logic [31:0] e0,
                           input logic [31:0] e1, input int t0, input int t1, input int td);
    int nout;
    int ndone;
    logic        s_valid;
    logic [31:0] s_idx, s_data, s_aa, s_wa;
    nout  = 0;
    ndone = 0;
    s_valid = 1'b0;
    s_idx = '0; s_data = '0; s_aa = '0; s_wa = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_e1", busy, 1);
    check("act_addr_e1", act_addr, 0);
    check("w_addr_e1", w_addr, 0);
    for (int c = 1; c <= td + 3; c++) begin
      out_ready = !(stall && c >= 6 && c <= 10);
      if (pulse) start = (c == 3);
      if (stall && c == 6) begin
        check("stall_w_addr", w_addr, 3);
        check("stall_act_addr", act_addr, 0);
        s_valid = out_valid; s_idx = out_idx; s_data = out_data;
        s_aa = act_addr; s_wa = w_addr;
      end
      if (stall && c == 10) begin
        check("stall_valid", out_valid, s_valid);
        check("stall_idx", out_idx, s_idx);
        check("stall_data", out_data, s_data);
        check("stall_aa", act_addr, s_aa);
        check("stall_wa", w_addr, s_wa);
        check("stall_data_val", out_data, e0);
      end
      if (out_valid && out_ready) begin
        check("out_idx", out_idx, nout);
        if (nout == 0) begin
          check("out0_data", out_data, e0);
          check("out0_cycle", c, t0);
        end else begin
          check("out1_data", out_data, e1);
          check("out1_cycle", c, t1);
        end
        nout++;
      end
      if (done) begin
        ndone++;
        check("done_cycle", c, td);
        check("busy_at_done", busy, 0);
      end
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("n_outputs", nout, 2);
    check("n_done", ndone, 1);
  endtask

  initial begin
    logic [31:0] ovf_exp;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    load(32'd8192, 32'd8192, 32'd0, 32'd8192, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_idx", out_idx, 0);
    check("rst_data", out_data, 0);
    check("rst_act_addr", act_addr, 0);
    check("rst_w_addr", w_addr, 0);
    tick();

    // Unity weights: 3 * 8192*8192 >> 13 = 24576
    run_layer(1'b0, 1'b0, 32'd24576, 32'd24576, 6, 12, 13);

    // ReLU clamp and bias-only node
    load(32'd8192, -32'sd8192, 32'd0, 32'd0, 32'd8192);
    run_layer(1'b0, 1'b0, 32'd0, 32'd1, 6, 12, 13);

    // Three products of 2^30
`ifdef MAC_SAT_EN
    ovf_exp = 32'd65535;
`else
    ovf_exp = 32'd0;
`endif
    load(32'd1 << 20, 32'd1 << 10, 32'd0, 32'd1 << 10, 32'd0);
    run_layer(1'b0, 1'b0, ovf_exp, ovf_exp, 6, 12, 13);

    // Backpressure: 5 stalled cycles on node 0
    load(32'd8192, 32'd8192, 32'd0, 32'd8192, 32'd0);
    run_layer(1'b1, 1'b0, 32'd24576, 32'd24576, 11, 17, 18);

    // Reset asserted during cycle E0+2
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_act_addr", act_addr, 0);
    check("mid_rst_w_addr", w_addr, 0);
    check("mid_rst_done", done, 0);
    tick();
    run_layer(1'b0, 1'b0, 32'd24576, 32'd24576, 6, 12, 13);

    // Start pulsed while busy is ignored
    run_layer(1'b0, 1'b1, 32'd24576, 32'd24576, 6, 12, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
